// File: rtl/lane_delay_sequencer.sv
// Central delay-programming controller for DDR3 PHY byte lanes. It takes delay-write commands,
// expands broadcasts into per-lane load pulses, keeps a readable shadow table and sequences set_out.
//
// state | meaning
// IDLE  | ready for a command or an apply request
// BCAST | issuing one lane load per cycle for a broadcast command
// SET   | set_out is registered high for the following cycle
module lane_delay_sequencer #(
    parameter int NUM_LANES = 2,
    parameter int DQ_WIDTH  = 8,
    parameter int DLY_WIDTH = 8,
    parameter int AUTO_SET  = 0,
    parameter int SEL_W     = $clog2(DQ_WIDTH + 2),
    parameter int LANE_W    = (NUM_LANES > 1) ? $clog2(NUM_LANES) : 1
) (
    input  logic                              clk_div,
    input  logic                              rst,
    input  logic                              cmd_valid,
    output logic                              cmd_ready,
    input  logic [LANE_W-1:0]                 cmd_lane,
    input  logic                              cmd_bcast,
    input  logic                              cmd_dir,
    input  logic [SEL_W-1:0]                  cmd_sel,
    input  logic [DLY_WIDTH-1:0]              cmd_data,
    input  logic                              apply,
    output logic [DLY_WIDTH-1:0]              dly_data_out,
    output logic [NUM_LANES*(DQ_WIDTH+2)-1:0] ld_odly,
    output logic [NUM_LANES*(DQ_WIDTH+1)-1:0] ld_idly,
    output logic                              set_out,
    output logic                              pending,
    output logic                              err,
    input  logic                              err_clr,
    input  logic [LANE_W-1:0]                 rd_lane,
    input  logic                              rd_dir,
    input  logic [SEL_W-1:0]                  rd_sel,
    output logic [DLY_WIDTH-1:0]              rd_data
);
    localparam int LDO_W = NUM_LANES * (DQ_WIDTH + 2);
    localparam int LDI_W = NUM_LANES * (DQ_WIDTH + 1);
    localparam int SH_N  = LDO_W + LDI_W;
    localparam int SH_W  = $clog2(SH_N);
    localparam logic [LANE_W-1:0] LAST_LANE = LANE_W'(NUM_LANES - 1);

    typedef enum logic [1:0] {S_IDLE, S_BCAST, S_SET} state_t;

    state_t                 r_state, w_state_nxt;
    logic [LANE_W-1:0]      r_lane_cnt, w_lane_nxt;
    logic                   r_apply_lat, w_apply_nxt;
    logic                   r_ready;
    logic                   r_cmd_dir;
    logic [SEL_W-1:0]       r_cmd_sel;
    logic [DLY_WIDTH-1:0]   r_cmd_data;
    logic [DLY_WIDTH-1:0]   r_dly_data;
    logic [LDO_W-1:0]       r_ld_odly, w_ld_odly;
    logic [LDI_W-1:0]       r_ld_idly, w_ld_idly;
    logic                   r_set_out, r_pending, r_err;
    logic [DLY_WIDTH-1:0]   r_rd_data, w_rd_val;
    logic [DLY_WIDTH-1:0]   r_shadow [SH_N];

    logic                   w_accept, w_cmd_legal, w_apply_any;
    logic                   w_capture, w_ld_en, w_ld_dir, w_set_issue, w_bcast_busy, w_err_set;
    logic [SEL_W-1:0]       w_ld_sel;
    logic [LANE_W-1:0]      w_ld_lane;
    logic [DLY_WIDTH-1:0]   w_ld_data;
    logic [SH_W-1:0]        w_wr_idx, w_rd_idx;

    function automatic logic f_legal(input logic dir, input logic [SEL_W-1:0] sel,
                                     input logic [LANE_W-1:0] lane, input logic chk_lane);
        logic ok;
        ok = 1'b1;
        if (int'(sel) > DQ_WIDTH + 1) ok = 1'b0;
        if (dir && int'(sel) == DQ_WIDTH + 1) ok = 1'b0;
        if (chk_lane && int'(lane) >= NUM_LANES) ok = 1'b0;
        return ok;
    endfunction

    // Input delays live after all output delays in the flat shadow table.
    function automatic int f_idx(input logic dir, input logic [SEL_W-1:0] sel,
                                 input logic [LANE_W-1:0] lane);
        if (dir) return LDO_W + int'(lane) * (DQ_WIDTH + 1) + int'(sel);
        return int'(lane) * (DQ_WIDTH + 2) + int'(sel);
    endfunction

    assign w_accept    = cmd_valid & r_ready & (r_state == S_IDLE);
    assign w_cmd_legal = f_legal(cmd_dir, cmd_sel, cmd_lane, ~cmd_bcast);
    assign w_apply_any = apply | r_apply_lat;

    always_comb begin
        w_state_nxt  = r_state;
        w_lane_nxt   = r_lane_cnt;
        w_apply_nxt  = r_apply_lat | apply;
        w_capture    = 1'b0;
        w_ld_en      = 1'b0;
        w_ld_dir     = r_cmd_dir;
        w_ld_sel     = r_cmd_sel;
        w_ld_lane    = r_lane_cnt;
        w_ld_data    = r_cmd_data;
        w_set_issue  = 1'b0;
        w_bcast_busy = 1'b0;
        w_err_set    = 1'b0;
        unique case (r_state)
            S_IDLE: begin
                if (w_accept) begin
                    w_capture = 1'b1;
                    if (!w_cmd_legal) begin
                        w_err_set   = 1'b1;
                        w_state_nxt = w_apply_any ? S_SET : S_IDLE;
                    end else begin
                        w_ld_en   = 1'b1;
                        w_ld_dir  = cmd_dir;
                        w_ld_sel  = cmd_sel;
                        w_ld_data = cmd_data;
                        w_ld_lane = cmd_bcast ? '0 : cmd_lane;
                        w_bcast_busy = cmd_bcast;
                        if (cmd_bcast && NUM_LANES > 1) begin
                            w_lane_nxt  = LANE_W'(1);
                            w_state_nxt = S_BCAST;
                        end else begin
                            w_state_nxt = (AUTO_SET != 0 || w_apply_any) ? S_SET : S_IDLE;
                        end
                    end
                end else if (w_apply_any) begin
                    w_state_nxt = S_SET;
                end
            end
            S_BCAST: begin
                w_ld_en      = 1'b1;
                w_bcast_busy = 1'b1;
                if (r_lane_cnt == LAST_LANE) begin
                    w_state_nxt = (AUTO_SET != 0 || w_apply_any) ? S_SET : S_IDLE;
                end else begin
                    w_lane_nxt = r_lane_cnt + LANE_W'(1);
                end
            end
            S_SET: begin
                w_set_issue = 1'b1;
                w_apply_nxt = 1'b0;
                w_state_nxt = S_IDLE;
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        w_ld_odly = '0;
        w_ld_idly = '0;
        if (w_ld_en && !w_ld_dir)
            w_ld_odly = LDO_W'(1) << (int'(w_ld_lane) * (DQ_WIDTH + 2) + int'(w_ld_sel));
        if (w_ld_en && w_ld_dir)
            w_ld_idly = LDI_W'(1) << (int'(w_ld_lane) * (DQ_WIDTH + 1) + int'(w_ld_sel));
        w_wr_idx = SH_W'(f_idx(w_ld_dir, w_ld_sel, w_ld_lane));
        w_rd_idx = SH_W'(f_idx(rd_dir, rd_sel, rd_lane));
        w_rd_val = '0;
        // Forward a same-cycle write so the read sees the new value.
        if (f_legal(rd_dir, rd_sel, rd_lane, 1'b1)) begin
            if (w_ld_en && w_wr_idx == w_rd_idx) w_rd_val = w_ld_data;
            else                                 w_rd_val = r_shadow[w_rd_idx];
        end
    end

    always_ff @(posedge clk_div or posedge rst) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_lane_cnt  <= '0;
            r_apply_lat <= 1'b0;
            r_ready     <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_lane_cnt  <= w_lane_nxt;
            r_apply_lat <= w_apply_nxt;
            r_ready     <= (w_state_nxt == S_IDLE) && !w_set_issue && !w_bcast_busy;
        end
    end

    always_ff @(posedge clk_div or posedge rst) begin
        if (rst) begin
            r_cmd_dir  <= 1'b0;
            r_cmd_sel  <= '0;
            r_cmd_data <= '0;
            r_dly_data <= '0;
            r_ld_odly  <= '0;
            r_ld_idly  <= '0;
            r_set_out  <= 1'b0;
            r_pending  <= 1'b0;
            r_err      <= 1'b0;
            r_rd_data  <= '0;
            for (int i = 0; i < SH_N; i++) r_shadow[i] <= '0;
        end else begin
            if (w_capture) begin
                r_cmd_dir  <= cmd_dir;
                r_cmd_sel  <= cmd_sel;
                r_cmd_data <= cmd_data;
            end
            if (w_ld_en) begin
                r_dly_data         <= w_ld_data;
                r_shadow[w_wr_idx] <= w_ld_data;
            end
            r_ld_odly <= w_ld_odly;
            r_ld_idly <= w_ld_idly;
            r_set_out <= w_set_issue;
            r_pending <= w_set_issue ? 1'b0 : (r_pending | w_ld_en);
            r_err     <= err_clr ? 1'b0 : (r_err | w_err_set);
            r_rd_data <= w_rd_val;
        end
    end

    assign cmd_ready    = r_ready;
    assign dly_data_out = r_dly_data;
    assign ld_odly      = r_ld_odly;
    assign ld_idly      = r_ld_idly;
    assign set_out      = r_set_out;
    assign pending      = r_pending;
    assign err          = r_err;
    assign rd_data      = r_rd_data;
endmodule

// File: tb/tb_lane_delay_sequencer.sv
// Directed bench for lane_delay_sequencer: two-lane manual-set, two-lane auto-set and
// four-lane instances driven from one linear sequence, outputs sampled on the falling edge.
module tb_lane_delay_sequencer;
    logic clk_div = 1'b0;
    always #5 clk_div = ~clk_div;

    logic       rst;
    logic [1:0] cmd_lane;
    logic       cmd_bcast, cmd_dir;
    logic [3:0] cmd_sel;
    logic [7:0] cmd_data;
    logic       err_clr;
    logic [1:0] rd_lane;
    logic       rd_dir;
    logic [3:0] rd_sel;
    logic       v0, v1, v2, ap0, ap1, ap2;

    logic        rdy0, set0, pend0, err0;
    logic [7:0]  dd0, rd0;
    logic [19:0] ldo0;
    logic [17:0] ldi0;
    logic        rdy1, set1, pend1, err1;
    logic [7:0]  dd1, rd1;
    logic [19:0] ldo1;
    logic [17:0] ldi1;
    logic        rdy2, set2, pend2, err2;
    logic [7:0]  dd2, rd2;
    logic [39:0] ldo2;
    logic [35:0] ldi2;

    int n_chk  = 0;
    int n_fail = 0;
    int cnt;

    lane_delay_sequencer #(.NUM_LANES(2), .DQ_WIDTH(8), .DLY_WIDTH(8), .AUTO_SET(0)) u0 (
        .clk_div(clk_div), .rst(rst), .cmd_valid(v0), .cmd_ready(rdy0),
        .cmd_lane(cmd_lane[0:0]), .cmd_bcast(cmd_bcast), .cmd_dir(cmd_dir), .cmd_sel(cmd_sel),
        .cmd_data(cmd_data), .apply(ap0), .dly_data_out(dd0), .ld_odly(ldo0), .ld_idly(ldi0),
        .set_out(set0), .pending(pend0), .err(err0), .err_clr(err_clr),
        .rd_lane(rd_lane[0:0]), .rd_dir(rd_dir), .rd_sel(rd_sel), .rd_data(rd0));

    lane_delay_sequencer #(.NUM_LANES(2), .DQ_WIDTH(8), .DLY_WIDTH(8), .AUTO_SET(1)) u1 (
        .clk_div(clk_div), .rst(rst), .cmd_valid(v1), .cmd_ready(rdy1),
        .cmd_lane(cmd_lane[0:0]), .cmd_bcast(cmd_bcast), .cmd_dir(cmd_dir), .cmd_sel(cmd_sel),
        .cmd_data(cmd_data), .apply(ap1), .dly_data_out(dd1), .ld_odly(ldo1), .ld_idly(ldi1),
        .set_out(set1), .pending(pend1), .err(err1), .err_clr(err_clr),
        .rd_lane(rd_lane[0:0]), .rd_dir(rd_dir), .rd_sel(rd_sel), .rd_data(rd1));

    lane_delay_sequencer #(.NUM_LANES(4), .DQ_WIDTH(8), .DLY_WIDTH(8), .AUTO_SET(0)) u2 (
        .clk_div(clk_div), .rst(rst), .cmd_valid(v2), .cmd_ready(rdy2),
        .cmd_lane(cmd_lane), .cmd_bcast(cmd_bcast), .cmd_dir(cmd_dir), .cmd_sel(cmd_sel),
        .cmd_data(cmd_data), .apply(ap2), .dly_data_out(dd2), .ld_odly(ldo2), .ld_idly(ldi2),
        .set_out(set2), .pending(pend2), .err(err2), .err_clr(err_clr),
        .rd_lane(rd_lane), .rd_dir(rd_dir), .rd_sel(rd_sel), .rd_data(rd2));

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_div);
        @(negedge clk_div);
    endtask

    task automatic cmd(input logic [1:0] lane, input logic bc, input logic dir,
                       input logic [3:0] sel, input logic [7:0] data);
        cmd_lane = lane; cmd_bcast = bc; cmd_dir = dir; cmd_sel = sel; cmd_data = data;
    endtask

    task automatic rd_at(input logic [1:0] lane, input logic dir, input logic [3:0] sel);
        rd_lane = lane; rd_dir = dir; rd_sel = sel;
        tick();
    endtask

    initial begin
        rst = 1'b1; v0 = 0; v1 = 0; v2 = 0; ap0 = 0; ap1 = 0; ap2 = 0; err_clr = 0;
        cmd(2'd0, 1'b0, 1'b0, 4'd0, 8'h00);
        rd_lane = 0; rd_dir = 0; rd_sel = 0;
        @(negedge clk_div);
        repeat (5) tick();

        // Reset state
        chk("rst_ldo", ldo0, 0);
        chk("rst_ldi", ldi0, 0);
        chk("rst_set", set0, 0);
        chk("rst_dly", dd0, 0);
        chk("rst_pend", pend0, 0);
        chk("rst_err", err0, 0);
        chk("rst_rd", rd0, 0);
        chk("rst_ready", rdy0, 0);
        chk("rst_ready2", rdy2, 0);
        rst = 1'b0;
        tick();
        chk("ready_after_rst", rdy0, 1);
        cnt = 0;
        for (int l = 0; l < 2; l++)
            for (int d = 0; d < 2; d++)
                for (int s = 0; s < 10; s++) begin
                    rd_at(2'(l), 1'(d), 4'(s));
                    if (rd0 !== 8'h00) cnt++;
                end
        chk("rd_all_zero", cnt, 0);

        // Unicast lane 1, output delay, sel 3
        cmd(2'd1, 1'b0, 1'b0, 4'd3, 8'h5A); v0 = 1;
        tick(); v0 = 0;
        chk("uc_ldo", ldo0, 20'h02000);
        chk("uc_ldi", ldi0, 0);
        chk("uc_dly", dd0, 8'h5A);
        chk("uc_set", set0, 0);
        chk("uc_pend", pend0, 1);
        chk("uc_ready", rdy0, 1);
        tick();
        chk("uc_ldo_off", ldo0, 0);
        chk("uc_pend_hold", pend0, 1);
        ap0 = 1;
        tick(); ap0 = 0;
        cnt = int'(set0);
        repeat (3) begin tick(); cnt += int'(set0); end
        chk("apply_one_set", cnt, 1);
        chk("apply_pend_clr", pend0, 0);
        rd_at(2'd1, 1'b0, 4'd3);
        chk("rd_uc", rd0, 8'h5A);

        // Back-to-back unicast, one per cycle
        cmd(2'd0, 1'b0, 1'b0, 4'd1, 8'h0F); v0 = 1;
        tick();
        chk("b2b_ld1", ldo0, 20'h00002);
        chk("b2b_rdy", rdy0, 1);
        cmd(2'd1, 1'b0, 1'b1, 4'd2, 8'hF0);
        tick(); v0 = 0;
        chk("b2b_ld2_i", ldi0, 18'h00800);
        chk("b2b_ld2_o", ldo0, 0);
        chk("b2b_dly", dd0, 8'hF0);
        tick();

        // Broadcast input delay, DQS (sel 8), apply one cycle later
        cmd(2'd0, 1'b1, 1'b1, 4'd8, 8'h21); v0 = 1;
        tick(); v0 = 0;
        chk("bc_ld0", ldi0, 18'h00100);
        chk("bc_rdy0", rdy0, 0);
        chk("bc_dly", dd0, 8'h21);
        chk("bc_set0", set0, 0);
        ap0 = 1;
        tick(); ap0 = 0;
        chk("bc_ld1", ldi0, 18'h20000);
        chk("bc_rdy1", rdy0, 0);
        chk("bc_set1", set0, 0);
        tick();
        chk("bc_set", set0, 1);
        chk("bc_ld_off", ldi0, 0);
        tick();
        chk("bc_set_off", set0, 0);
        chk("bc_rdy_back", rdy0, 1);
        chk("bc_pend", pend0, 0);
        rd_at(2'd0, 1'b1, 4'd8);
        chk("rd_bc_l0", rd0, 8'h21);
        rd_at(2'd1, 1'b1, 4'd8);
        chk("rd_bc_l1", rd0, 8'h21);

        // Illegal: input delay has no DM
        cmd(2'd0, 1'b0, 1'b1, 4'd9, 8'h77); v0 = 1;
        tick(); v0 = 0;
        chk("ill_ldo", ldo0, 0);
        chk("ill_ldi", ldi0, 0);
        chk("ill_err", err0, 1);
        cmd(2'd0, 1'b0, 1'b0, 4'd12, 8'h66); v0 = 1;
        tick(); v0 = 0;
        chk("ill_sel_ld", ldo0 | 20'(ldi0), 0);
        cmd(2'd0, 1'b0, 1'b0, 4'd9, 8'h33); v0 = 1;
        tick(); v0 = 0;
        chk("dm_ld", ldo0, 20'h00200);
        chk("err_sticky", err0, 1);
        err_clr = 1;
        tick(); err_clr = 0;
        chk("err_clr", err0, 0);
        rd_at(2'd0, 1'b0, 4'd9);
        chk("rd_dm", rd0, 8'h33);
        rd_at(2'd0, 1'b0, 4'd12);
        chk("rd_ill_addr", rd0, 0);

        // AUTO_SET instance: writes accepted at T and T+3
        cmd(2'd0, 1'b0, 1'b0, 4'd0, 8'h11); v1 = 1;
        tick(); v1 = 0;
        chk("as_ld1", ldo1, 20'h00001);
        chk("as_set_t1", set1, 0);
        chk("as_rdy_t1", rdy1, 0);
        tick();
        chk("as_set1", set1, 1);
        chk("as_ld_t2", ldo1, 0);
        chk("as_rdy_t2", rdy1, 0);
        tick();
        chk("as_set_t3", set1, 0);
        chk("as_rdy_t3", rdy1, 1);
        cmd(2'd1, 1'b0, 1'b0, 4'd1, 8'h22); v1 = 1;
        tick(); v1 = 0;
        chk("as_ld2", ldo1, 20'h00800);
        chk("as_set_t4", set1, 0);
        tick();
        chk("as_set2", set1, 1);
        chk("as_ld_t5", ldo1, 0);
        tick();
        chk("as_set_t6", set1, 0);

        // Reset in the middle of a four-lane broadcast
        cmd(2'd3, 1'b1, 1'b0, 4'd2, 8'h44); v2 = 1;
        tick(); v2 = 0;
        chk("mr_ld0", ldo2, 40'h4);
        rst = 1'b1;
        #1;
        chk("mr_ld_abort", ldo2, 0);
        cnt = 0;
        repeat (4) begin tick(); if ((|ldo2) || (|ldi2) || set2) cnt++; end
        rst = 1'b0;
        repeat (4) begin tick(); if ((|ldo2) || (|ldi2) || set2) cnt++; end
        chk("mr_no_strobes", cnt, 0);
        chk("mr_ready", rdy2, 1);
        rd_at(2'd0, 1'b0, 4'd2);
        chk("mr_rd_l0", rd2, 0);
        rd_at(2'd1, 1'b0, 4'd2);
        chk("mr_rd_l1", rd2, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
